ntm_scalar_stream_summation: RTL
================================

NTM_SCALAR_STREAM_SUMMATION -- requirements
Module: ntm_scalar_stream_summation

Interface
REQ-001 Parameter DATA_SIZE, default 16: operand and result width in bits.
REQ-002 Parameter CONTROL_SIZE, default 8: width of the operand-count field.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: the single clock, rising edge.
REQ-005 Port rst, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: request a new summation; honoured only while ready=1.
REQ-007 Port length_in, input, CONTROL_SIZE: number of operands; latched when start is honoured.
REQ-008 Port ready, output, 1: block is in IDLE and accepts start.
REQ-009 Port data_in_valid, input, 1: an operand is present on data_in.
REQ-010 Port data_in_ready, output, 1: block accepts an operand this cycle.
REQ-011 Port data_in, input, DATA_SIZE: unsigned operand.
REQ-012 Port data_out, output, DATA_SIZE: summation result.
REQ-013 Port done, output, 1: one-cycle pulse; data_out is valid.
REQ-014 Port overflow, output, 1: sticky flag for the current summation; set when any add carries out of DATA_SIZE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 IDLE: ready=1 and data_in_ready=0. On start=1, latch length_in, clear the accumulator, clear overflow and clear the beat counter.
REQ-017 IDLE with start=1 and length_in=0: go to DONE with data_out=0 and overflow=0.
REQ-018 IDLE with start=1 and length_in>0: go to ACCUM.
REQ-019 ACCUM: data_in_ready=1 and ready=0. A beat is accepted only when data_in_valid and data_in_ready are both 1. Each accepted beat updates acc <= acc + data_in and increments the counter.
REQ-020 When the beat with count = length-1 is accepted, go to DONE on the next edge. The result appears 1 cycle after the last accepted beat.
REQ-021 Gaps in data_in_valid SHALL stall the accumulation without losing state. start is ignored outside IDLE.
REQ-022 DONE: done=1 for exactly 1 cycle, then return to IDLE. data_out and overflow hold their values until the next honoured start.
REQ-023 Arithmetic is unsigned. The adder is DATA_SIZE+1 bits wide, and the carry bit feeds overflow.
REQ-024 The counter is CONTROL_SIZE bits wide. length_in = 2^CONTROL_SIZE-1 SHALL be fully supported with no counter wrap.

Reset
REQ-025 While rst=0, the block SHALL be in IDLE with ready=1, data_in_ready=0, done=0, data_out=0, overflow=0, counter=0 and latched length=0.
REQ-026 Reset asserted mid-ACCUM or in DONE SHALL abort the summation immediately. No done pulse follows release.

Configuration
REQ-027 Macro NTM_SCALAR_SUMMATION_SATURATE_EN controls overflow handling.
REQ-028 When the macro is defined, an add that carries out SHALL clamp acc to 2^DATA_SIZE-1, and the accumulator stays clamped for later beats.
REQ-029 When the macro is undefined, acc SHALL wrap modulo 2^DATA_SIZE.
REQ-030 The overflow flag behaves identically in both builds, and the port list is unchanged.

Structure
REQ-031 Package ntm_scalar_summation_pkg SHALL hold:
- the state enum (IDLE, ACCUM, DONE);
- default DATA_SIZE and CONTROL_SIZE constants.
REQ-032 One sub-module, ntm_scalar_adder_core, SHALL provide the DATA_SIZE-wide add with carry-out and optional saturation. The FSM, counter and registers live in the top level.

Verification
REQ-033 Reset: rst=0 then 1, no stimulus. Required: ready=1, data_out=0, done=0, overflow=0 from reset onward.
REQ-034 Basic sum: start with length=4, operands 1,2,3,4 back-to-back. Required: done one cycle after the 4th beat, data_out=10, overflow=0.
REQ-035 Stalls and ignored start: length=3, operands 100,200,300 with 2-cycle valid gaps, and start pulsed mid-ACCUM. Required: data_out=600, exactly one done pulse.
REQ-036 Zero length: start with length=0. Required: done on the next cycle, data_out=0, no data_in_ready asserted.
REQ-037 Overflow: DATA_SIZE=16, operands 0xFFF0 then 0x0020.
- Without the macro: data_out=0x0010, overflow=1.
- With the macro: data_out=0xFFFF, overflow=1.
REQ-038 Reset mid-operation: rst=0 after 2 of 5 beats, then restart with length=2, operands 7,8. Required: no done during the abort, then data_out=15, overflow=0.

Source files
------------

// File: rtl/ntm_scalar_summation_pkg.sv
// ntm_scalar_summation_pkg: state encoding and default widths for the scalar stream summation block.
package ntm_scalar_summation_pkg;
  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_CONTROL_SIZE = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/ntm_scalar_adder_core.sv
// ntm_scalar_adder_core: DATA_SIZE-wide unsigned add with carry-out.
// With NTM_SCALAR_SUMMATION_SATURATE_EN defined, a carrying add clamps to all-ones.
module ntm_scalar_adder_core
  import ntm_scalar_summation_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic [DATA_SIZE-1:0] a_i,
  input  logic [DATA_SIZE-1:0] b_i,
  output logic [DATA_SIZE-1:0] sum_o,
  output logic                 carry_o
);
  logic [DATA_SIZE:0] full;
  assign full = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = full[DATA_SIZE];
`ifdef NTM_SCALAR_SUMMATION_SATURATE_EN
  assign sum_o = full[DATA_SIZE] ? '1 : full[DATA_SIZE-1:0];
`else
  assign sum_o = full[DATA_SIZE-1:0];
`endif
endmodule

// File: rtl/ntm_scalar_stream_summation.sv
// ntm_scalar_stream_summation: sums a stream of length_in unsigned operands with a sticky overflow flag.
// Overflow handling (wrap or clamp) is selected by NTM_SCALAR_SUMMATION_SATURATE_EN in the adder core.
module ntm_scalar_stream_summation
  import ntm_scalar_summation_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int CONTROL_SIZE = DEF_CONTROL_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CONTROL_SIZE-1:0] length_in,
  output logic                    ready,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  input  logic [DATA_SIZE-1:0]    data_in,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic                    done,
  output logic                    overflow
);
  state_t                  state_q, state_d;
  logic [DATA_SIZE-1:0]    acc_q, acc_d, sum;
  logic [CONTROL_SIZE-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic                    ovf_q, ovf_d, carry, beat;
  ntm_scalar_adder_core #(.DATA_SIZE(DATA_SIZE)) u_add (
    .a_i    (acc_q),
    .b_i    (data_in),
    .sum_o  (sum),
    .carry_o(carry)
  );
  assign ready = state_q == IDLE;
  assign data_in_ready = state_q == ACCUM;
  assign done = state_q == DONE;
  assign data_out = acc_q;
  assign overflow = ovf_q;
  assign beat = data_in_ready && data_in_valid;
  assign cnt_inc = cnt_q + CONTROL_SIZE'(1);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (ready && start) begin
      len_d = length_in;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      state_d = length_in == '0 ? DONE : ACCUM;
    end
    // comparing the incremented count against the length avoids any wrap at the maximum length
    if (beat) begin
      acc_d = sum;
      ovf_d = ovf_q | carry;
      cnt_d = cnt_inc;
      state_d = cnt_inc == len_q ? DONE : ACCUM;
    end
    if (done) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
